issue_queue: RTL



---
 rtl/issue_queue.sv | 95 +++++++++
 1 files changed

// File: rtl/issue_queue.sv
// In-order issue queue between decode and register-read. The head entry issues
// only when the busy-register vector shows no RAW/WAW hazard on it.
package issue_queue_pkg;
  typedef struct packed {
    logic [5:0]  uopcode;
    logic [1:0]  exu_type;
    logic        has_rd;
    logic        has_rs1;
    logic        has_rs2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  imm_type;
    logic [19:0] packed_imm;
    logic        taken;
    logic        shadowed;
    logic [31:0] pc;
  } queue_item_t;
endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  queue_item_t       in_item,
  input  logic [31:0]       busy,
  output logic              out_valid,
  input  logic              out_ready,
  output queue_item_t       out_item,
  output logic              sb_set_valid,
  output logic [4:0]        sb_set_rd,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  queue_item_t      mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic             push, pop;
  logic             raw1, raw2, waw;

  // Ready depends on registered occupancy only, so a pop cannot free a slot
  // for a push in the same cycle.
  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready & ~flush;

  assign out_item = mem[rp];

  // x0 never creates a hazard regardless of what busy[0] says.
  assign raw1 = out_item.has_rs1 & (out_item.rs1 != 5'd0) & busy[out_item.rs1];
  assign raw2 = out_item.has_rs2 & (out_item.rs2 != 5'd0) & busy[out_item.rs2];
  assign waw  = out_item.has_rd  & (out_item.rd  != 5'd0) & busy[out_item.rd];

  assign out_valid    = (count != '0) & ~raw1 & ~raw2 & ~waw & ~flush;
  assign pop          = out_valid & out_ready;
  assign sb_set_valid = pop & out_item.has_rd & (out_item.rd != 5'd0);
  assign sb_set_rd    = out_item.rd;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_item;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count == '0));
  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL);
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
    PTR_W'(wp - rp) == count[PTR_W-1:0]);

endmodule
